// File: rtl/qif_spike_decoder_if.sv
// qif_spike_decoder_if: valid/ready channel that carries inter-spike intervals
// from the decoder (master) to its consumer (slave).
interface qif_spike_decoder_if #(
    parameter int ISI_W = 16
);
    logic [ISI_W-1:0] isi_data;
    logic             isi_valid;
    logic             isi_ready;

    modport master (output isi_data, isi_valid, input isi_ready);
    modport slave  (input isi_data, isi_valid, output isi_ready);
endinterface

// File: rtl/qif_spike_decoder.sv
// qif_spike_decoder: spike detection and inter-spike interval readout for a QIF voltage stream.
// Define QIF_DEC_RATE_EN to add the windowed spike-rate counter.
module qif_spike_decoder #(
    parameter logic signed [7:0] VPEAK  = 8'sd50,
    parameter int                ISI_W  = 16,
    parameter int                WINDOW = 256,
    parameter int                RATE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [7:0]        v_in,
    input  logic                     v_valid,
    output logic                     spike,
    qif_spike_decoder_if.master      isi,
    output logic                     overrun,
    output logic [RATE_W-1:0]        rate_count,
    output logic                     rate_valid
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic             armed, hit, spk, emit;
    logic [ISI_W-1:0] isi_cnt, cnt_next, isi_new;

    if (WINDOW < 2) begin : g_window_check
        $error("WINDOW must be at least 2");
    end

    assign hit = v_in >= VPEAK;
    assign spk = v_valid && armed && hit;

    // isi_new doubles as the saturating increment and as the emitted interval
    always_comb begin
        state_next = state;
        cnt_next   = isi_cnt;
        emit       = 1'b0;
        isi_new    = (&isi_cnt) ? isi_cnt : isi_cnt + 1'b1;
        if (v_valid && state == IDLE && spk) begin
            state_next = RUN;
            cnt_next   = '0;
        end else if (v_valid && state == RUN) begin
            emit     = spk;
            cnt_next = spk ? '0 : isi_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            armed         <= 1'b1;
            isi_cnt       <= '0;
            spike         <= 1'b0;
            isi.isi_data  <= '0;
            isi.isi_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            isi_cnt <= cnt_next;
            spike   <= spk;
            if (v_valid)
                armed <= !hit;
            if (emit && (!isi.isi_valid || isi.isi_ready)) begin
                isi.isi_data  <= isi_new;
                isi.isi_valid <= 1'b1;
            end else begin
                if (emit)
                    overrun <= 1'b1;
                if (isi.isi_ready)
                    isi.isi_valid <= 1'b0;
            end
        end
    end

`ifdef QIF_DEC_RATE_EN
    localparam int             WW       = $clog2(WINDOW);
    localparam logic [WW-1:0]  WIN_LAST = WW'(WINDOW - 1);

    logic [WW-1:0]     win_cnt;
    logic [RATE_W-1:0] spk_cnt, spk_sum;
    logic              win_end;

    assign spk_sum = (&spk_cnt) ? spk_cnt : spk_cnt + RATE_W'(spk);
    assign win_end = v_valid && win_cnt == WIN_LAST;

    // the final sample's spike is folded into spk_sum before publishing
    always_ff @(posedge clk) begin
        if (rst_n) begin
            win_cnt    <= '0;
            spk_cnt    <= '0;
            rate_count <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= win_end;
            if (win_end)
                rate_count <= spk_sum;
            if (v_valid) begin
                win_cnt <= win_end ? '0 : win_cnt + 1'b1;
                spk_cnt <= win_end ? '0 : spk_sum;
            end
        end
    end
`else
    assign rate_count = '0;
    assign rate_valid = 1'b0;
`endif
endmodule

// File: doc/qif_spike_decoder.md
# qif_spike_decoder

- Readout for the QIF neuron's 8-bit signed membrane-voltage stream.
- Detects spike events and measures the inter-spike interval (ISI) in samples.
- Delivers each ISI over a valid/ready handshake and, optionally, a windowed spike-rate count.
- Sits at the neuron's output, converting the voltage trace back into numeric values for downstream logic or the next layer's input current.

## Interface
Parameters:
- VPEAK, 50: signed 8-bit spike threshold.
- ISI_W, 16: ISI counter/output width.
- WINDOW, 256: rate window length in valid samples (≥2).
- RATE_W, 8: rate count width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-high.
- v_in  in  8  membrane voltage sample, signed two's complement.
- v_valid  in  1  v_in carries a new sample this cycle.
- spike  out  1  one-cycle pulse per detected spike.
- isi_data  out  ISI_W  interval between last two spikes, in samples.
- isi_valid  out  1  isi_data pending.
- isi_ready  in  1  consumer accepts isi_data.
- overrun  out  1  sticky: an ISI was dropped.
- rate_count  out  RATE_W  spikes counted in last completed window.
- rate_valid  out  1  one-cycle pulse when rate_count updates.

## Operation
- Only cycles with v_valid=1 are samples. All other cycles leave the state unchanged, apart from handshake completion.
- All comparisons are signed 8-bit; 8'hEC is -20, not 236.
- Spike detection:
  - A spike is a sample with v_in ≥ VPEAK while the armed flag is 1.
  - The armed flag is set by any sample with v_in < VPEAK and cleared by a spike.
  - A sustained v_in ≥ VPEAK yields exactly one spike.
  - Reset sets armed=1.
- FSM:
  - IDLE: no spike seen yet. First spike → RUN; no ISI emitted.
  - RUN: isi_cnt counts samples since the last spike, saturating at 2^ISI_W−1. On a spike, ISI = isi_cnt+1 (saturating), i.e. the difference in sample index, and isi_cnt restarts at 0.
- Output register:
  - On an ISI in RUN: if isi_valid=0, or isi_valid=1 with isi_ready=1 in the same cycle, load isi_data and assert isi_valid.
  - Otherwise keep the old isi_data, set overrun (sticky until reset) and drop the new ISI.
  - isi_valid && isi_ready with no new ISI → isi_valid deasserts next cycle.
  - isi_data is stable while isi_valid=1 and isi_ready=0.
- The rate path is described under Configuration.
- Reset mid-operation: FSM→IDLE, counters cleared, pending ISI discarded, armed=1.

## Timing
- Reset values: spike=0, isi_data=0, isi_valid=0, overrun=0, rate_count=0, rate_valid=0.
- spike is registered, asserted in the cycle after the spiking sample's v_valid cycle.
- isi_valid rises in the same cycle as the corresponding spike pulse; latency is 1 cycle.
- isi_ready is sampled on the rising edge. Transfer occurs when isi_valid && isi_ready.
- rate_valid is asserted in the cycle after the window's final sample.
- Back-to-back spikes on consecutive valid samples are impossible, since re-arming needs a sub-threshold sample; minimum ISI = 2.

## Configuration
- QIF_DEC_RATE_EN defined:
  - A window counter counts valid samples; a spike counter counts spikes, saturating at 2^RATE_W−1.
  - After WINDOW samples, rate_count ← the spike count (including a spike on the final sample), rate_valid pulses and both counters restart.
- QIF_DEC_RATE_EN undefined: rate logic is absent; rate_count=0 and rate_valid=0 constantly.

## Test plan
- Reset, then samples -20,10,50,-20,0,0,60,-20 with isi_ready=1: spike pulses after samples 2 and 6; one ISI=4; overrun=0.
- Sustained v_in=70 for 5 samples after a sub-threshold sample: exactly one spike pulse.
- Three spikes with isi_ready=0 throughout: first ISI held with isi_valid=1 and unchanged data; overrun=1 after the third spike. Raising isi_ready then transfers the first ISI.
- Spike arriving in the same cycle as the isi_valid/isi_ready transfer: the new ISI loads, isi_valid stays 1, overrun=0.
- v_in=-128 and v_in=127 with VPEAK=50: no spike, then spike. Gaps with v_valid=0 do not change ISI.
- With QIF_DEC_RATE_EN, WINDOW=16 and a spike every 4 samples: rate_count=4 with a rate_valid pulse every 16 samples. Reset mid-window: rate_count=0, next window counted from scratch.
